// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: sequential MAC stage behind the 8x8 radix-4 Booth multiplier.
// Sums LEN signed 16-bit products into an ACC_W-bit accumulator, presents the
// group sum on a held valid/ready output, then starts the next group from zero.
// Optional feature macro: BOOTH_MAC_SATURATE_EN (clamp on signed overflow
// instead of wrapping; the overflow flag is reported either way).
module booth_mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN   = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    overflow,
    output logic [CNT_W-1:0]        count
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(LEN - 1);

    state_t                   state_reg, state_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]         count_reg, count_next;
    logic                     sticky_reg, sticky_next;
    logic signed [ACC_W-1:0]  acc_out_reg, acc_out_next;
    logic                     overflow_reg, overflow_next;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum_raw;
    logic signed [ACC_W-1:0]  sum_val;
    logic                     sum_ovf;
    logic                     accept;
    logic                     last_product;

    // Product sign-extended to accumulator width; overflow is the classic
    // "same-sign operands, different-sign result" test on the raw sum.
    assign prod_ext = ACC_W'(product);
    assign sum_raw  = acc_reg + prod_ext;
    assign sum_ovf  = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_reg[ACC_W-1]);

`ifdef BOOTH_MAC_SATURATE_EN
    // On overflow both operands share a sign, so that sign picks the clamp rail.
    assign sum_val = sum_ovf ? (acc_reg[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    // Wrapping arithmetic: the rails are unused in this build.
    logic unused_rails;
    assign unused_rails = ACC_MAX[0] ^ ACC_MIN[0];
    assign sum_val      = sum_raw;
`endif

    assign in_ready     = (state_reg == ACCUM);
    assign out_valid    = (state_reg == DONE);
    assign accept       = in_valid && in_ready;
    assign last_product = (count_reg == LAST_CNT);
    assign acc_out      = acc_out_reg;
    assign overflow     = overflow_reg;
    assign count        = count_reg;

    // State and datapath registers; rst returns everything to an empty group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ACCUM;
            acc_reg      <= '0;
            count_reg    <= '0;
            sticky_reg   <= 1'b0;
            acc_out_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            count_reg    <= count_next;
            sticky_reg   <= sticky_next;
            acc_out_reg  <= acc_out_next;
            overflow_reg <= overflow_next;
        end
    end

    // Next-state logic: clear beats any handshake; the final product of a group
    // publishes the sum and restarts the accumulator in the same edge.
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        count_next    = count_reg;
        sticky_next   = sticky_reg;
        acc_out_next  = acc_out_reg;
        overflow_next = overflow_reg;

        if (clear) begin
            state_next    = ACCUM;
            acc_next      = '0;
            count_next    = '0;
            sticky_next   = 1'b0;
            overflow_next = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (last_product) begin
                            acc_out_next  = sum_val;
                            overflow_next = sticky_reg | sum_ovf;
                            state_next    = DONE;
                            acc_next      = '0;
                            count_next    = '0;
                            sticky_next   = 1'b0;
                        end else begin
                            acc_next    = sum_val;
                            count_next  = count_reg + CNT_W'(1);
                            sticky_next = sticky_reg | sum_ovf;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

endmodule
